// File: rtl/msx_rom_mapper_detect_if.sv
// ioctl download bus plus the ROM description produced by the mapper detector.
// The master side streams the image and consumes the result; the slave side is the detector.
interface msx_rom_mapper_detect_if;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic [24:0] rom_size;
    logic [5:0]  rom_mapper;
    logic        loaded;
    logic        busy;

    modport master (
        output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
        input  rom_size, rom_mapper, loaded, busy
    );

    modport slave (
        input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
        output rom_size, rom_mapper, loaded, busy
    );
endinterface

// File: rtl/msx_rom_mapper_detect.sv
// MSX cartridge mapper detector.
// Watches the ioctl download of a ROM image, tracks its length and counts
// "LD (nn),A" stores to the bank-switch addresses of the common mappers.
// When the download ends, it picks the most plausible mapper and holds the
// result (with loaded=1) until the next download begins.
module msx_rom_mapper_detect #(
    parameter int          CNT_W      = 16,
    parameter logic [24:0] LINEAR_MAX = 25'h10000
) (
    input  logic                   clk,
    input  logic                   reset_n,
    msx_rom_mapper_detect_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DECIDE,
        ST_DONE
    } state_t;

    localparam logic [5:0] MAPPER_NO_UNKNOWN = 6'd0;
    localparam logic [5:0] MAPPER_ASCII8     = 6'd1;
    localparam logic [5:0] MAPPER_ASCII16    = 6'd2;
    localparam logic [5:0] MAPPER_KONAMI     = 6'd3;
    localparam logic [5:0] MAPPER_KONAMI_SCC = 6'd4;
    localparam logic [5:0] MAPPER_LINEAR     = 6'd6;

    localparam logic [7:0]       OP_LD_NN_A = 8'h32;
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    state_t state;
    logic   dl_prev;
    logic   dl_rise;
    logic   dl_fall;
    logic   scan_enter;

    logic [24:0] size_q;
    logic [5:0]  mapper_q;
    logic        loaded_q;
    logic        busy_q;

    // Window: op byte, lo byte, fill level and the address the next byte must have.
    logic [7:0]  win_op;
    logic [7:0]  win_lo;
    logic [1:0]  win_cnt;
    logic [24:0] next_addr;

    logic        wr_accept;
    logic [24:0] addr_plus1;
    logic [1:0]  eff_cnt;
    logic        win_match;
    logic [15:0] nn;

    logic dec_scc, dec_kon, dec_a8, dec_a16;
    logic hit_scc, hit_kon, hit_a8, hit_a16;

    logic [CNT_W-1:0] cnt_scc, cnt_kon, cnt_a8, cnt_a16;

    logic [CNT_W-1:0] best_cnt;
    logic [5:0]       best_code;
    logic [5:0]       decided_mapper;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value, input logic en);
        if (en && (value != CNT_MAX)) begin
            return value + 1'b1;
        end
        return value;
    endfunction

    assign dl_rise    = bus.ioctl_download & ~dl_prev;
    assign dl_fall    = ~bus.ioctl_download & dl_prev;
    assign scan_enter = dl_rise && (state != ST_SCAN);

    // Classify the incoming write against the window contents.
    always_comb begin
        wr_accept  = (state == ST_SCAN) && bus.ioctl_download && bus.ioctl_wr;
        addr_plus1 = bus.ioctl_addr + 25'd1;
        eff_cnt    = (bus.ioctl_addr == next_addr) ? win_cnt : 2'd0;
        win_match  = (eff_cnt == 2'd2) && (win_op == OP_LD_NN_A);
        nn         = {bus.ioctl_dout, win_lo};
    end

    // Map a store target address onto the mappers that use it as a bank register.
    always_comb begin
        dec_scc = 1'b0;
        dec_kon = 1'b0;
        dec_a8  = 1'b0;
        dec_a16 = 1'b0;
        case (nn)
            16'h5000, 16'h9000, 16'hB000: dec_scc = 1'b1;
            16'h4000, 16'h8000, 16'hA000: dec_kon = 1'b1;
            16'h6800, 16'h7800:           dec_a8  = 1'b1;
            16'h77FF:                     dec_a16 = 1'b1;
            16'h6000: begin
                dec_kon = 1'b1;
                dec_a8  = 1'b1;
                dec_a16 = 1'b1;
            end
            16'h7000: begin
                dec_scc = 1'b1;
                dec_a8  = 1'b1;
                dec_a16 = 1'b1;
            end
            default: ;
        endcase
    end

    // Shift image bytes through the window and flag a completed bank-switch store.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            win_op    <= 8'h00;
            win_lo    <= 8'h00;
            win_cnt   <= 2'd0;
            next_addr <= 25'd0;
            hit_scc   <= 1'b0;
            hit_kon   <= 1'b0;
            hit_a8    <= 1'b0;
            hit_a16   <= 1'b0;
        end else if (scan_enter) begin
            win_op    <= 8'h00;
            win_lo    <= 8'h00;
            win_cnt   <= 2'd0;
            next_addr <= 25'd0;
            hit_scc   <= 1'b0;
            hit_kon   <= 1'b0;
            hit_a8    <= 1'b0;
            hit_a16   <= 1'b0;
        end else begin
            hit_scc <= wr_accept && win_match && dec_scc;
            hit_kon <= wr_accept && win_match && dec_kon;
            hit_a8  <= wr_accept && win_match && dec_a8;
            hit_a16 <= wr_accept && win_match && dec_a16;
            if (wr_accept) begin
                next_addr <= addr_plus1;
                if (win_match) begin
                    win_cnt <= 2'd0;
                end else begin
                    case (eff_cnt)
                        2'd0: begin
                            win_op  <= bus.ioctl_dout;
                            win_cnt <= 2'd1;
                        end
                        2'd1: begin
                            win_lo  <= bus.ioctl_dout;
                            win_cnt <= 2'd2;
                        end
                        default: begin
                            win_op <= win_lo;
                            win_lo <= bus.ioctl_dout;
                        end
                    endcase
                end
            end
        end
    end

    // Saturating pattern counters, bumped the cycle after a matching store completes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_scc <= '0;
            cnt_kon <= '0;
            cnt_a8  <= '0;
            cnt_a16 <= '0;
        end else if (scan_enter) begin
            cnt_scc <= '0;
            cnt_kon <= '0;
            cnt_a8  <= '0;
            cnt_a16 <= '0;
        end else begin
            cnt_scc <= sat_inc(cnt_scc, hit_scc);
            cnt_kon <= sat_inc(cnt_kon, hit_kon);
            cnt_a8  <= sat_inc(cnt_a8,  hit_a8);
            cnt_a16 <= sat_inc(cnt_a16, hit_a16);
        end
    end

    // Pick the mapper: small images are linear, otherwise the strongest counter wins with SCC > KON > A8 > A16 on ties.
    always_comb begin
        best_cnt  = cnt_scc;
        best_code = MAPPER_KONAMI_SCC;
        if (cnt_kon > best_cnt) begin
            best_cnt  = cnt_kon;
            best_code = MAPPER_KONAMI;
        end
        if (cnt_a8 > best_cnt) begin
            best_cnt  = cnt_a8;
            best_code = MAPPER_ASCII8;
        end
        if (cnt_a16 > best_cnt) begin
            best_cnt  = cnt_a16;
            best_code = MAPPER_ASCII16;
        end
        if (size_q <= LINEAR_MAX) begin
            decided_mapper = MAPPER_LINEAR;
        end else if (best_cnt == '0) begin
            decided_mapper = MAPPER_NO_UNKNOWN;
        end else begin
            decided_mapper = best_code;
        end
    end

    // Download sequencing, image sizing and the registered result outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            dl_prev  <= 1'b0;
            size_q   <= 25'd0;
            mapper_q <= MAPPER_NO_UNKNOWN;
            loaded_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            dl_prev <= bus.ioctl_download;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (dl_rise) begin
                        state    <= ST_SCAN;
                        size_q   <= 25'd0;
                        loaded_q <= 1'b0;
                        busy_q   <= 1'b1;
                    end
                end
                ST_SCAN: begin
                    if (wr_accept && (addr_plus1 > size_q)) begin
                        size_q <= addr_plus1;
                    end
                    if (dl_fall) begin
                        state <= ST_DECIDE;
                    end
                end
                ST_DECIDE: begin
                    if (dl_rise) begin
                        state    <= ST_SCAN;
                        size_q   <= 25'd0;
                        loaded_q <= 1'b0;
                        busy_q   <= 1'b1;
                    end else begin
                        state    <= ST_DONE;
                        mapper_q <= decided_mapper;
                        loaded_q <= 1'b1;
                        busy_q   <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.rom_size   = size_q;
    assign bus.rom_mapper = mapper_q;
    assign bus.loaded     = loaded_q;
    assign bus.busy       = busy_q;

endmodule
